// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer in front of decoder_sys: symbol FIFO, feed/tail/drain FSM and output tagging.
// Define VITERBI_CTRL_STATS_EN to add saturating frame and underrun counters.
module viterbi_frame_ctrl #(
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned TRACEBACK_LAT = 15,
  parameter int unsigned LEN_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sym_valid,
  input  logic [1:0]       sym_data,
  output logic             sym_ready,
  input  logic             frame_start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [2:0]       cfg_constraint_length,
  output logic [1:0]       dec_encoded_bits,
  output logic [2:0]       dec_choose_constraint_length,
  input  logic             dec_final_output,
  output logic             out_valid,
  output logic             out_bit,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             err_cfg,
  output logic             err_underrun
`ifdef VITERBI_CTRL_STATS_EN
  ,
  output logic [15:0]      stat_frames,
  output logic [15:0]      stat_underruns
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned DW = $clog2(TRACEBACK_LAT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_TAIL  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]         state;
  logic [1:0]         mem [FIFO_DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr, fill;
  logic               empty, full, push, pop;
  logic [LEN_W-1:0]   frame_cnt;
  logic [2:0]         tail_cnt;
  logic [DW-1:0]      drain_cnt;
  logic [TRACEBACK_LAT-1:0] tag_v, tag_l;
  logic               feed_last, drain_end;

  assign fill      = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (fill == (AW+1)'(FIFO_DEPTH));
  assign sym_ready = !full;
  assign push      = sym_valid && !full;
  assign pop       = (state == S_FEED) && !empty;
  assign busy      = (state != S_IDLE);
  assign feed_last = (state == S_FEED) && (frame_cnt == LEN_W'(1));
  assign drain_end = (state == S_DRAIN) && (drain_cnt == DW'(1));

  // Tag depth TRACEBACK_LAT lines up with the decoder bit for each fed symbol.
  assign out_valid = tag_v[TRACEBACK_LAT-1];
  assign out_last  = tag_l[TRACEBACK_LAT-1];
  assign out_bit   = out_valid & dec_final_output;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= sym_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                        <= S_IDLE;
      wr_ptr                       <= '0;
      rd_ptr                       <= '0;
      frame_cnt                    <= '0;
      tail_cnt                     <= '0;
      drain_cnt                    <= '0;
      dec_encoded_bits             <= '0;
      dec_choose_constraint_length <= 3'b011;
      done                         <= 1'b0;
      err_cfg                      <= 1'b0;
      err_underrun                 <= 1'b0;
      tag_v                        <= '0;
      tag_l                        <= '0;
    end else begin
      done             <= 1'b0;
      err_cfg          <= 1'b0;
      dec_encoded_bits <= 2'b00;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      tag_v <= {tag_v[TRACEBACK_LAT-2:0], state == S_FEED};
      tag_l <= {tag_l[TRACEBACK_LAT-2:0], feed_last};

      case (state)
        S_IDLE: begin
          if (frame_start) begin
            if (cfg_constraint_length < 3'd3 || frame_len == '0) begin
              err_cfg <= 1'b1;
            end else begin
              dec_choose_constraint_length <= cfg_constraint_length;
              frame_cnt                    <= frame_len;
              err_underrun                 <= 1'b0;
              state                        <= S_FEED;
            end
          end
        end
        S_FEED: begin
          if (!empty) dec_encoded_bits <= mem[rd_ptr[AW-1:0]];
          else        err_underrun     <= 1'b1;
          if (feed_last) begin
            tail_cnt <= dec_choose_constraint_length - 3'd1;
            state    <= S_TAIL;
          end else begin
            frame_cnt <= frame_cnt - 1'b1;
          end
        end
        S_TAIL: begin
          if (tail_cnt == 3'd1) begin
            drain_cnt <= DW'(TRACEBACK_LAT);
            state     <= S_DRAIN;
          end else begin
            tail_cnt <= tail_cnt - 3'd1;
          end
        end
        default: begin
          if (drain_end) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
      endcase
    end
  end

`ifdef VITERBI_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_frames    <= '0;
      stat_underruns <= '0;
    end else begin
      if (drain_end && stat_frames != 16'hFFFF) stat_frames <= stat_frames + 16'd1;
      if ((state == S_FEED) && empty && stat_underruns != 16'hFFFF)
        stat_underruns <= stat_underruns + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Directed bench for viterbi_frame_ctrl with a queue scoreboard of expected decoded bits.
module tb_viterbi_frame_ctrl;
  localparam int TL    = 15;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             sym_valid;
  logic [1:0]       sym_data;
  logic             sym_ready;
  logic             frame_start;
  logic [LEN_W-1:0] frame_len;
  logic [2:0]       cfg_k;
  logic [1:0]       dec_encoded_bits;
  logic [2:0]       dec_choose;
  logic             dec_final_output;
  logic             out_valid, out_bit, out_last;
  logic             busy, done, err_cfg, err_underrun;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  int lasts    = 0;

  logic [1:0] symq  [$];
  logic [1:0] edq   [$];
  logic [1:0] exp_q [$];

  // Decoder stand-in: parity bit appears TL edges after the edge that launched its symbol.
  logic [TL-2:0] dl = '0;
  always @(posedge clk) dl <= {dl[TL-3:0], ^dec_encoded_bits};
  assign dec_final_output = dl[TL-2];

  always #5 clk = ~clk;

  viterbi_frame_ctrl #(.FIFO_DEPTH(16), .TRACEBACK_LAT(TL), .LEN_W(LEN_W)) dut (
    .clk                          (clk),
    .reset                        (reset),
    .sym_valid                    (sym_valid),
    .sym_data                     (sym_data),
    .sym_ready                    (sym_ready),
    .frame_start                  (frame_start),
    .frame_len                    (frame_len),
    .cfg_constraint_length        (cfg_k),
    .dec_encoded_bits             (dec_encoded_bits),
    .dec_choose_constraint_length (dec_choose),
    .dec_final_output             (dec_final_output),
    .out_valid                    (out_valid),
    .out_bit                      (out_bit),
    .out_last                     (out_last),
    .busy                         (busy),
    .done                         (done),
    .err_cfg                      (err_cfg),
    .err_underrun                 (err_underrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      logic [1:0] e;
      pulses++;
      if (out_last === 1'b1) lasts++;
      chk("sb_has_entry", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_bit", out_bit, e[1]);
        chk("out_last", out_last, e[0]);
      end
    end else begin
      chk("quiet_out", {out_bit, out_last}, 2'b00);
    end
  end

  task automatic push_sym(input logic [1:0] s);
    sym_valid = 1'b1;
    sym_data  = s;
    chk("push_ready", sym_ready, 1);
    tick();
    sym_valid = 1'b0;
    symq.push_back(s);
  endtask

  task automatic start_frame(input int len, input logic [2:0] k);
    for (int i = 0; i < len; i++) begin
      logic [1:0] s;
      s = (symq.size() > 0) ? symq.pop_front() : 2'b00;
      exp_q.push_back({^s, i == len - 1});
      edq.push_back(s);
    end
    pulses      = 0;
    lasts       = 0;
    frame_start = 1'b1;
    frame_len   = LEN_W'(len);
    cfg_k       = k;
    tick();
    frame_start = 1'b0;
    chk("busy_start", busy, 1);
    chk("k_out", dec_choose, k);
  endtask

  task automatic feed_and_drain(input int len, input int k, input bit hold);
    int n;
    for (int i = 0; i < len; i++) begin
      tick();
      if (hold && i == 0) chk("held_accept_ready", sym_ready, 1);
      if (hold && i == 1) sym_valid = 1'b0;
      chk("dec_feed", dec_encoded_bits, edq.pop_front());
      chk("out_valid_timing", out_valid, (i + 1) >= TL);
    end
    for (int j = 0; j < k - 1; j++) begin
      tick();
      chk("dec_tail", dec_encoded_bits, 2'b00);
      chk("busy_tail", busy, 1);
    end
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk("done_latency", n, TL);
    chk("busy_at_done", busy, 0);
    tick();
    chk("done_pulse_width", done, 0);
    chk("pulse_count", pulses, len);
    chk("last_count", lasts, 1);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    logic [1:0] seq [15];
    seq = '{2'b11, 2'b11, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00,
            2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
    reset = 1'b1; sym_valid = 1'b0; sym_data = 2'b00;
    frame_start = 1'b0; frame_len = '0; cfg_k = 3'b011;

    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_sym_ready", sym_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_cfg", err_cfg, 0);
    chk("rst_err_underrun", err_underrun, 0);
    chk("rst_dec_bits", dec_encoded_bits, 2'b00);
    chk("rst_dec_k", dec_choose, 3'b011);
    chk("rst_out_valid", out_valid, 0);

    // Full-length frame of the reference sequence, K=3.
    for (int i = 0; i < 15; i++) push_sym(seq[i]);
    start_frame(15, 3'b011);
    feed_and_drain(15, 3, 1'b0);
    chk("t1_no_underrun", err_underrun, 0);

    // Rejected configurations leave the FIFO alone.
    for (int i = 0; i < 5; i++) push_sym(2'(i + 1));
    frame_start = 1'b1; frame_len = 8'd5; cfg_k = 3'b010;
    tick();
    frame_start = 1'b0;
    chk("errk_pulse", err_cfg, 1);
    chk("errk_busy", busy, 0);
    tick();
    chk("errk_pulse_end", err_cfg, 0);
    frame_start = 1'b1; frame_len = 8'd0; cfg_k = 3'b011;
    tick();
    frame_start = 1'b0;
    chk("errlen_pulse", err_cfg, 1);
    chk("errlen_busy", busy, 0);
    tick();
    chk("errlen_pulse_end", err_cfg, 0);
    chk("err_keeps_k", dec_choose, 3'b011);

    // Underrun: 5 queued, frame of 8, K=5.
    start_frame(8, 3'b101);
    feed_and_drain(8, 5, 1'b0);
    chk("underrun_sticky", err_underrun, 1);

    // Fill the FIFO; the 17th symbol waits for the first pop.
    for (int i = 0; i < 16; i++) push_sym(2'(i) ^ 2'(i >> 2));
    chk("full_not_ready", sym_ready, 0);
    sym_valid = 1'b1; sym_data = 2'b10;
    tick();
    tick();
    chk("held_not_ready", sym_ready, 0);
    symq.push_back(2'b10);
    start_frame(17, 3'b011);
    chk("first_feed_full", sym_ready, 0);
    feed_and_drain(17, 3, 1'b1);
    chk("underrun_cleared", err_underrun, 0);

    // Reset during the 5th FEED cycle aborts everything.
    for (int i = 0; i < 10; i++) push_sym(2'(3 - (i % 4)));
    start_frame(10, 3'b110);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_ready", sym_ready, 1);
    chk("abort_k", dec_choose, 3'b011);
    chk("abort_dec", dec_encoded_bits, 2'b00);
    exp_q.delete();
    edq.delete();
    symq.delete();
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("abort_quiet_valid", out_valid, 0);
      chk("abort_quiet_done", done, 0);
    end
    push_sym(2'b01);
    push_sym(2'b11);
    start_frame(2, 3'b011);
    feed_and_drain(2, 3, 1'b0);
    chk("post_abort_underrun", err_underrun, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
